// File: rtl/mig_arb_pkg.sv
// Shared types and constants for the two-stream MIG write arbiter.
// Used by mig_write_arbiter and stream_addr_gen. The MIG_ARB_PINGPONG_EN option is handled in those files.
package mig_arb_pkg;

  localparam int NUM_SRC  = 2;
  localparam int PHRASE_W = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

  // Grant state that serves a given source index.
  function automatic arb_state_t grant_state(input logic src);
    return src ? GRANT1 : GRANT0;
  endfunction

endpackage

// File: rtl/stream_addr_gen.sv
// Per-stream phrase pointer with frame wrap, frame-done pulse and sticky framing error.
// With MIG_ARB_PINGPONG_EN the stream alternates between two frame buffers.
module stream_addr_gen
  import mig_arb_pkg::*;
#(
  parameter int ADDR_W        = 27,
  parameter int FRAME_PHRASES = 4800
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              accept,
  input  logic              tlast,
  output logic [ADDR_W-1:0] offset,
  output logic              frame_done,
  output logic              err
`ifdef MIG_ARB_PINGPONG_EN
  ,
  output logic              bank_done
`endif
);

  localparam int PTR_W = (FRAME_PHRASES > 1) ? $clog2(FRAME_PHRASES) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FRAME_PHRASES - 1);

  logic [PTR_W-1:0] ptr;
  logic             at_end;

  assign at_end = (ptr == PTR_LAST);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ptr        <= '0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      frame_done <= accept && tlast;
      if (accept) begin
        ptr <= (tlast || at_end) ? '0 : ptr + 1'b1;
        // A frame is well formed only when tlast and the last pointer slot coincide.
        if (tlast != at_end) err <= 1'b1;
      end
    end
  end

`ifdef MIG_ARB_PINGPONG_EN
  logic bank;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      bank      <= 1'b0;
      bank_done <= 1'b0;
    end else if (accept && tlast) begin
      bank_done <= bank;
      bank      <= ~bank;
    end
  end

  assign offset = ADDR_W'(ptr) + (bank ? ADDR_W'(FRAME_PHRASES) : '0);
`else
  assign offset = ADDR_W'(ptr);
`endif

endmodule

// File: rtl/mig_write_arbiter.sv
// Round-robin burst arbiter sharing one MIG write port between two phrase streams.
// Define MIG_ARB_PINGPONG_EN for double-buffered frames and the bank_done_out port.
module mig_write_arbiter
  import mig_arb_pkg::*;
#(
  parameter int                ADDR_W        = 27,
  parameter int                FRAME_PHRASES = 4800,
  parameter int                BURST_LEN     = 8,
  parameter logic [ADDR_W-1:0] BASE0         = '0,
  parameter logic [ADDR_W-1:0] BASE1         = ADDR_W'('h4000)
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                s0_tvalid,
  output logic                s0_tready,
  input  logic [PHRASE_W-1:0] s0_tdata,
  input  logic                s0_tlast,
  input  logic                s1_tvalid,
  output logic                s1_tready,
  input  logic [PHRASE_W-1:0] s1_tdata,
  input  logic                s1_tlast,
  output logic                cmd_tvalid,
  input  logic                cmd_tready,
  output logic [ADDR_W-1:0]   cmd_addr,
  output logic [PHRASE_W-1:0] cmd_tdata,
  output logic                cmd_src,
  output logic [1:0]          frame_done_out,
  output logic [1:0]          err_out
`ifdef MIG_ARB_PINGPONG_EN
  ,
  output logic [1:0]          bank_done_out
`endif
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

  arb_state_t           state;
  logic                 last_grant;
  logic [BEAT_W-1:0]    beat_cnt;
  logic                 gsel;
  logic                 out_free;
  logic                 grant_acc;
  logic                 grant_rel;
  logic [NUM_SRC-1:0]   req;
  logic [NUM_SRC-1:0]   last_in;
  logic [NUM_SRC-1:0]   accept;
  logic [PHRASE_W-1:0]  data_in [NUM_SRC];
  logic [ADDR_W-1:0]    offset  [NUM_SRC];

  // Handshake and release decode. Every output is assigned on every pass.
  always_comb begin
    req        = {s1_tvalid, s0_tvalid};
    last_in    = {s1_tlast, s0_tlast};
    data_in[0] = s0_tdata;
    data_in[1] = s1_tdata;
    gsel       = (state == GRANT1);
    out_free   = !cmd_tvalid || cmd_tready;
    s0_tready  = (state == GRANT0) && out_free;
    s1_tready  = (state == GRANT1) && out_free;
    accept     = {s1_tvalid && s1_tready, s0_tvalid && s0_tready};
    grant_acc  = accept[gsel];
    grant_rel  = !req[gsel] || (grant_acc && (last_in[gsel] || beat_cnt == BEAT_LAST));
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the clock edge, whatever the statement order.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      beat_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          // On a tie, the stream that was not served last wins.
          if (req[0] && (!req[1] || last_grant)) state <= grant_state(1'b0);
          else if (req[1])                       state <= grant_state(1'b1);
        end
        GRANT0, GRANT1: begin
          if (grant_rel) begin
            state      <= IDLE;
            last_grant <= gsel;
            beat_cnt   <= '0;
          end else if (grant_acc) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Single-stage output register. An accept is only possible when the stage is
  // empty or draining, so a held command is never overwritten.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      // NOTE: the wide data register is reset as well, because its reset value is
      // visible on cmd_tdata and is part of the defined reset state.
      cmd_tvalid <= 1'b0;
      cmd_addr   <= '0;
      cmd_tdata  <= '0;
      cmd_src    <= 1'b0;
    end else if (|accept) begin
      cmd_tvalid <= 1'b1;
      cmd_addr   <= (gsel ? BASE1 : BASE0) + offset[gsel];
      cmd_tdata  <= data_in[gsel];
      cmd_src    <= gsel;
    end else if (cmd_tready) begin
      cmd_tvalid <= 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    stream_addr_gen #(
      .ADDR_W       (ADDR_W),
      .FRAME_PHRASES(FRAME_PHRASES)
    ) u_addr_gen (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .accept    (accept[i]),
      .tlast     (last_in[i]),
      .offset    (offset[i]),
      .frame_done(frame_done_out[i]),
      .err       (err_out[i])
`ifdef MIG_ARB_PINGPONG_EN
      ,
      .bank_done (bank_done_out[i])
`endif
    );
  end

endmodule

// File: tb/tb_mig_write_arbiter.sv
// Self-checking bench for mig_write_arbiter: directed phases plus randomized traffic
// checked against a frame-position scoreboard. It honours MIG_ARB_PINGPONG_EN.
module tb_mig_write_arbiter;

  localparam int ADDR_W = 27;
  localparam int FP     = 8;
  localparam int BL     = 4;
  localparam logic [ADDR_W-1:0] B0 = 27'h100;
  localparam logic [ADDR_W-1:0] B1 = 27'h4000;
`ifdef MIG_ARB_PINGPONG_EN
  localparam int PP = 1;
`else
  localparam int PP = 0;
`endif

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b1;
  logic              s0_tvalid = 1'b0, s1_tvalid = 1'b0;
  logic              s0_tready, s1_tready;
  logic [127:0]      s0_tdata = '0, s1_tdata = '0;
  logic              s0_tlast = 1'b0, s1_tlast = 1'b0;
  logic              cmd_tvalid;
  logic              cmd_tready = 1'b0;
  logic [ADDR_W-1:0] cmd_addr;
  logic [127:0]      cmd_tdata;
  logic              cmd_src;
  logic [1:0]        frame_done_out, err_out;
`ifdef MIG_ARB_PINGPONG_EN
  logic [1:0]        bank_done_out;
`endif

  always #5 clk_in = ~clk_in;

  mig_write_arbiter #(
    .ADDR_W(ADDR_W), .FRAME_PHRASES(FP), .BURST_LEN(BL), .BASE0(B0), .BASE1(B1)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .s0_tvalid(s0_tvalid), .s0_tready(s0_tready), .s0_tdata(s0_tdata), .s0_tlast(s0_tlast),
    .s1_tvalid(s1_tvalid), .s1_tready(s1_tready), .s1_tdata(s1_tdata), .s1_tlast(s1_tlast),
    .cmd_tvalid(cmd_tvalid), .cmd_tready(cmd_tready), .cmd_addr(cmd_addr),
    .cmd_tdata(cmd_tdata), .cmd_src(cmd_src),
    .frame_done_out(frame_done_out), .err_out(err_out)
`ifdef MIG_ARB_PINGPONG_EN
    , .bank_done_out(bank_done_out)
`endif
  );

  typedef struct packed {
    logic              src;
    logic [ADDR_W-1:0] addr;
    logic [127:0]      data;
  } exp_t;

  exp_t         q[$];
  int           pos[2];
  logic [1:0]   bank, m_err, exp_fd, exp_bank;
  logic         m_valid;
  int           beat[2], flen[2], next_len[2];
  logic         rand_len = 1'b0;
  logic [127:0] cur_data[2];
  logic [1:0]   cur_last;
  int           tests = 0, fails = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expd);
    tests++;
    assert (obs === expd) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expd);
    end
  endtask

  function automatic int pick_len();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7) return FP;
    if (r < 9) return $urandom_range(1, FP - 1);
    return $urandom_range(FP + 1, FP + 4);
  endfunction

  task automatic drive_src();
    s0_tdata = cur_data[0]; s0_tlast = cur_last[0];
    s1_tdata = cur_data[1]; s1_tlast = cur_last[1];
  endtask

  task automatic new_beat(input int s);
    cur_data[s] = {$urandom, $urandom, $urandom, $urandom};
    cur_last[s] = (beat[s] == flen[s] - 1);
  endtask

  task automatic advance(input int s);
    if (cur_last[s]) begin
      beat[s] = 0;
      flen[s] = rand_len ? pick_len() : next_len[s];
    end else begin
      beat[s]++;
    end
    new_beat(s);
  endtask

  task automatic model_reset();
    q.delete();
    bank = '0; m_err = '0; exp_fd = '0; exp_bank = '0; m_valid = 1'b0;
    for (int s = 0; s < 2; s++) begin
      pos[s] = 0; beat[s] = 0; flen[s] = next_len[s];
      new_beat(s);
    end
    drive_src();
  endtask

  // Frame-level model of one accepted source phrase.
  task automatic model_accept(input int s);
    exp_t e;
    e.src  = s[0];
    e.addr = (s == 0 ? B0 : B1) + ADDR_W'(PP * FP * int'(bank[s]) + pos[s]);
    e.data = cur_data[s];
    q.push_back(e);
    if (cur_last[s]) begin
      if (pos[s] != FP - 1) m_err[s] = 1'b1;
      exp_fd[s]   = 1'b1;
      exp_bank[s] = bank[s];
      bank[s]     = ~bank[s];
      pos[s]      = 0;
    end else if (pos[s] == FP - 1) begin
      m_err[s] = 1'b1;
      pos[s]   = 0;
    end else begin
      pos[s]++;
    end
  endtask

  // One clock: compare outputs, record handshakes, then advance past the edge.
  task automatic tick();
    logic [1:0] hs;
    #1;
    check("cmd_tvalid", cmd_tvalid, m_valid);
    if (m_valid && q.size() > 0) begin
      check("cmd_addr", cmd_addr, q[0].addr);
      check("cmd_tdata", cmd_tdata, q[0].data);
      check("cmd_src", cmd_src, q[0].src);
    end
    check("frame_done", frame_done_out, exp_fd);
    check("err_out", err_out, m_err);
`ifdef MIG_ARB_PINGPONG_EN
    for (int s = 0; s < 2; s++)
      if (exp_fd[s]) check("bank_done", bank_done_out[s], exp_bank[s]);
`endif
    check("tready_exclusive", s0_tready && s1_tready, 1'b0);
    hs = {s1_tvalid && s1_tready, s0_tvalid && s0_tready};
    if (m_valid && cmd_tready && q.size() > 0) void'(q.pop_front());
    m_valid = (hs != 2'b00) || (m_valid && !cmd_tready);
    exp_fd  = '0;
    for (int s = 0; s < 2; s++) if (hs[s]) model_accept(s);
    @(posedge clk_in);
    @(negedge clk_in);
    for (int s = 0; s < 2; s++) if (hs[s]) advance(s);
    drive_src();
  endtask

  task automatic do_reset();
    s0_tvalid = 1'b0; s1_tvalid = 1'b0;
    rst_in = 1'b0;
    #1;
    model_reset();
    check("rst_cmd_tvalid", cmd_tvalid, 1'b0);
    check("rst_cmd_addr", cmd_addr, '0);
    check("rst_cmd_tdata", cmd_tdata, '0);
    check("rst_cmd_src", cmd_src, 1'b0);
    check("rst_s0_tready", s0_tready, 1'b0);
    check("rst_s1_tready", s1_tready, 1'b0);
    check("rst_frame_done", frame_done_out, 2'b00);
    check("rst_err", err_out, 2'b00);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  initial begin
    logic [ADDR_W-1:0] addrs[9];
    int n, fd_cnt;
    logic exp_v;

    next_len[0] = FP; next_len[1] = FP;
    @(negedge clk_in);

    // Single stream: one full frame then the start of the next.
    do_reset();
    cmd_tready = 1'b1; s0_tvalid = 1'b1;
    n = 0; fd_cnt = 0;
    for (int c = 0; c < 60 && n < 9; c++) begin
      tick();
      if (cmd_tvalid) begin
        addrs[n] = cmd_addr;
        if (n < 8) fd_cnt += int'(frame_done_out[0]);
        n++;
      end
    end
    check("single_count", n, 9);
    for (int i = 0; i < 9; i++)
      check("single_addr", addrs[i], B0 + ADDR_W'((i % FP) + PP * FP * (i / FP)));
    check("single_fd_once", fd_cnt, 1);
    check("single_err", err_out, 2'b00);

    // Contention: both saturated; four beats, bubble, alternating sources.
    do_reset();
    s0_tvalid = 1'b1; s1_tvalid = 1'b1;
    n = 0;
    while (n < 12 && !cmd_tvalid) begin tick(); n++; end
    check("rr_first_seen", cmd_tvalid, 1'b1);
    check("rr_first_src", cmd_src, 1'b0);
    check("rr_first_addr", cmd_addr, B0);
    for (int i = 0; i < 20; i++) begin
      exp_v = ((i % 5) != 4);
      check("rr_valid", cmd_tvalid, exp_v);
      if (exp_v) check("rr_src", cmd_src, ((i % 10) >= 5));
      tick();
    end

    // Backpressure mid-burst.
    do_reset();
    s0_tvalid = 1'b1;
    n = 0;
    while (n < 12 && !cmd_tvalid) begin tick(); n++; end
    tick();
    cmd_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_tready_low", s0_tready, 1'b0);
      check("bp_valid_held", cmd_tvalid, 1'b1);
    end
    cmd_tready = 1'b1;
    repeat (20) tick();
    s0_tvalid = 1'b0;
    repeat (6) tick();
    check("bp_drained", q.size(), 0);

    // Short frame followed by good frames.
    next_len[0] = 3;
    do_reset();
    next_len[0] = FP;
    s0_tvalid = 1'b1;
    n = 0;
    for (int c = 0; c < 80 && n < 19; c++) begin
      tick();
      if (cmd_tvalid) begin
        if (n == 3) check("short_next_base", cmd_addr, B0 + ADDR_W'(PP * FP));
        n++;
      end
    end
    check("short_count", n, 19);
    check("short_err_sticky", err_out, 2'b01);

    // Randomized traffic with random frame lengths and backpressure.
    rand_len = 1'b1;
    for (int c = 0; c < 600; c++) begin
      s0_tvalid  = ($urandom_range(0, 3) != 0);
      s1_tvalid  = ($urandom_range(0, 3) != 0);
      cmd_tready = ($urandom_range(0, 3) != 0);
      tick();
    end
    s0_tvalid = 1'b0; s1_tvalid = 1'b0; cmd_tready = 1'b1;
    repeat (6) tick();
    check("rand_drained", q.size(), 0);

    // Asynchronous reset in the middle of a burst.
    rand_len = 1'b0;
    do_reset();
    s0_tvalid = 1'b1; s1_tvalid = 1'b1;
    n = 0;
    while (n < 12 && !cmd_tvalid) begin tick(); n++; end
    tick();
    check("pre_reset_valid", cmd_tvalid, 1'b1);
    rst_in = 1'b0;
    #1;
    check("async_reset_drop", cmd_tvalid, 1'b0);
    model_reset();
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    n = 0;
    while (n < 12 && !cmd_tvalid) begin tick(); n++; end
    check("post_reset_seen", cmd_tvalid, 1'b1);
    check("post_reset_src", cmd_src, 1'b0);
    check("post_reset_addr", cmd_addr, B0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
